// File: rtl/fft_buf_pkg.sv
// Shared definitions for the FFT magnitude buffer.
// Used by the writer and by the peak-search reader.
package fft_buf_pkg;

  localparam int N_BINS = 128;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;

  typedef enum logic [1:0] {
    WAIT_SOP,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/fft_mag_wr_mag_approx.sv
// Approximate |z| = max + min/2 of a complex bin.
// Holds the stage-1 register of the writer pipeline.
module mag_approx #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic                     clk_256k,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  input  logic                     in_vld,
  input  logic        [ADDR_W-1:0] in_idx,
  output logic                     out_vld,
  output logic        [ADDR_W-1:0] out_idx,
  output logic        [DATA_W-1:0] out_mag
);

  logic [DATA_W-1:0] re_u;
  logic [DATA_W-1:0] im_u;
  logic [DATA_W-1:0] abs_re_d, abs_re_q;
  logic [DATA_W-1:0] abs_im_d, abs_im_q;
  logic [ADDR_W-1:0] idx_d, idx_q;
  logic              vld_d, vld_q;
  logic [DATA_W-1:0] mx;
  logic [DATA_W-1:0] mn;

  // Unsigned abs so that -2^(W-1) maps to 2^(W-1).
  always_comb begin
    re_u     = in_re;
    im_u     = in_im;
    vld_d    = in_vld;
    abs_re_d = abs_re_q;
    abs_im_d = abs_im_q;
    idx_d    = idx_q;
    if (in_vld) begin
      abs_re_d = re_u[DATA_W-1] ? ('0 - re_u) : re_u;
      abs_im_d = im_u[DATA_W-1] ? ('0 - im_u) : im_u;
      idx_d    = in_idx;
    end
  end

  // Stage-1 register.
  always_ff @(posedge clk_256k or negedge rst_n) begin
    if (!rst_n) begin
      abs_re_q <= '0;
      abs_im_q <= '0;
      idx_q    <= '0;
      vld_q    <= 1'b0;
    end else begin
      abs_re_q <= abs_re_d;
      abs_im_q <= abs_im_d;
      idx_q    <= idx_d;
      vld_q    <= vld_d;
    end
  end

  // Max plus half of min; peaks at 1.5*2^(W-1), so no carry out.
  always_comb begin
    if (abs_re_q >= abs_im_q) begin
      mx = abs_re_q;
      mn = abs_im_q;
    end else begin
      mx = abs_im_q;
      mn = abs_re_q;
    end
    out_mag = mx + (mn >> 1);
    out_vld = vld_q;
    out_idx = idx_q;
  end

endmodule

// File: rtl/fft_mag_wr.sv
// FFT magnitude buffer writer: frames bins into the RAM,
// then holds the buffer until the reader releases it.
module fft_mag_wr #(
  parameter int N_BINS = fft_buf_pkg::N_BINS,
  parameter int DATA_W = fft_buf_pkg::DATA_W,
  parameter int ADDR_W = fft_buf_pkg::ADDR_W
) (
  input  logic                     clk_256k,
  input  logic                     rst_n,
  input  logic signed [DATA_W-1:0] fft_re,
  input  logic signed [DATA_W-1:0] fft_im,
  input  logic                     fft_valid,
  input  logic                     fft_sop,
  input  logic                     fft_eop,
  input  logic                     rd_done,
  output logic                     wr_en,
  output logic        [ADDR_W-1:0] wr_addr,
  output logic        [DATA_W-1:0] wr_data,
  output logic                     wr_done,
  output logic                     frame_err
);

  import fft_buf_pkg::*;

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] NB = CW'(N_BINS);

  state_e            state_d, state_q;
  logic [CW-1:0]     cnt_d, cnt_q;
  logic              err_d, err_q;
  logic              done_d, done_q;
  logic              en_d, en_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] data_d, data_q;

  logic              s1_in_vld;
  logic [ADDR_W-1:0] s1_in_idx;
  logic              s1_vld;
  logic [ADDR_W-1:0] s1_idx;
  logic [DATA_W-1:0] s1_mag;

  mag_approx #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mag (
    .clk_256k (clk_256k),
    .rst_n    (rst_n),
    .in_re    (fft_re),
    .in_im    (fft_im),
    .in_vld   (s1_in_vld),
    .in_idx   (s1_in_idx),
    .out_vld  (s1_vld),
    .out_idx  (s1_idx),
    .out_mag  (s1_mag)
  );

  // Frame FSM and bin counter; cnt_d is the beat total so far.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    s1_in_vld = 1'b0;
    s1_in_idx = cnt_q[ADDR_W-1:0];
    unique case (state_q)
      WAIT_SOP, WRITE: begin
        if (fft_valid) begin
          if (fft_sop) begin
            err_d     = (state_q == WRITE);
            s1_in_vld = 1'b1;
            s1_in_idx = '0;
            cnt_d     = CW'(1);
            state_d   = WRITE;
          end else if (state_q == WRITE) begin
            s1_in_vld = (cnt_q < NB);
            if (cnt_q < NB) cnt_d = cnt_q + CW'(1);
          end
          if (fft_eop && (fft_sop || state_q == WRITE)) begin
            if (cnt_d >= NB) begin
              state_d = DONE;
            end else begin
              err_d   = 1'b1;
              state_d = WAIT_SOP;
              cnt_d   = '0;
            end
          end
        end
      end
      default: begin
        if (rd_done) begin
          state_d = WAIT_SOP;
          cnt_d   = '0;
        end
      end
    endcase
  end

  // Stage 2 and status; done waits for the last write to drain.
  always_comb begin
    en_d   = s1_vld;
    addr_d = s1_vld ? s1_idx : addr_q;
    data_d = s1_vld ? s1_mag : data_q;
    done_d = (state_q == DONE) && !rd_done && (done_q || !s1_vld);
  end

  // All writer state.
  always_ff @(posedge clk_256k or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_SOP;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= done_d;
      en_q    <= en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign wr_en     = en_q;
  assign wr_addr   = addr_q;
  assign wr_data   = data_q;
  assign wr_done   = done_q;
  assign frame_err = err_q;

endmodule

// File: tb/tb_fft_mag_wr.sv
// Directed bench for fft_mag_wr with a write scoreboard.
// Expected writes are queued at drive time, popped on wr_en.
module tb_fft_mag_wr;

  logic               clk_256k = 1'b0;
  logic               rst_n = 1'b0;
  logic signed [15:0] fft_re = '0;
  logic signed [15:0] fft_im = '0;
  logic               fft_valid = 1'b0;
  logic               fft_sop = 1'b0;
  logic               fft_eop = 1'b0;
  logic               rd_done = 1'b0;
  logic               wr_en;
  logic [7:0]         wr_addr;
  logic [15:0]        wr_data;
  logic               wr_done;
  logic               frame_err;

  typedef struct {
    int addr;
    int data;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   err_cnt = 0;
  int   e0;

  fft_mag_wr dut (
    .clk_256k  (clk_256k),
    .rst_n     (rst_n),
    .fft_re    (fft_re),
    .fft_im    (fft_im),
    .fft_valid (fft_valid),
    .fft_sop   (fft_sop),
    .fft_eop   (fft_eop),
    .rd_done   (rd_done),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_done   (wr_done),
    .frame_err (frame_err)
  );

  always #5 clk_256k = ~clk_256k;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int mag(input int re, input int im);
    int a, b;
    a = (re < 0) ? -re : re;
    b = (im < 0) ? -im : im;
    if (a >= b) return a + b / 2;
    return b + a / 2;
  endfunction

  // Scoreboard: every write must match the oldest expectation.
  always @(negedge clk_256k) begin
    if (frame_err) err_cnt++;
    if (wr_en) begin
      if (sb.size() == 0) begin
        chk("wr_unexpected", 32'(wr_addr), -1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_addr", 32'(wr_addr), e.addr);
        chk("wr_data", 32'(wr_data), e.data);
      end
    end
  end

  task automatic beat(input int re, input int im, input bit sop,
                      input bit eop, input bit exp_wr, input int addr);
    exp_t e;
    fft_re    = re[15:0];
    fft_im    = im[15:0];
    fft_sop   = sop;
    fft_eop   = eop;
    fft_valid = 1'b1;
    if (exp_wr) begin
      e.addr = addr;
      e.data = mag(re, im);
      sb.push_back(e);
    end
    @(negedge clk_256k);
    fft_valid = 1'b0;
    fft_sop   = 1'b0;
    fft_eop   = 1'b0;
  endtask

  task automatic frame(input int n, input bit exp_wr,
                       input int variant, input bit eop_last);
    int re, im;
    for (int i = 0; i < n; i++) begin
      if (variant == 0) begin
        re = i;
        im = -2 * i;
        if (i == 5) begin
          re = -32768;
          im = -32768;
        end
      end else begin
        re = -i;
        im = 3 * i;
      end
      beat(re, im, i == 0, eop_last && (i == n - 1),
           exp_wr && (i < 128), i);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_256k);
  endtask

  task automatic release_buf();
    rd_done = 1'b1;
    @(negedge clk_256k);
    rd_done = 1'b0;
    chk("rd_done_clears", 32'(wr_done), 0);
  endtask

  initial begin
    idle(2);
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_wr_done", 32'(wr_done), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    rst_n = 1'b1;
    idle(2);

    // Clean frame, bin 5 at full negative scale.
    frame(128, 1, 0, 1);
    chk("done_k0", 32'(wr_done), 0);
    idle(1);
    chk("last_wr_en", 32'(wr_en), 1);
    chk("done_k1", 32'(wr_done), 0);
    idle(1);
    chk("done_k2", 32'(wr_done), 1);
    chk("err_clean", err_cnt, 0);

    // A frame arriving while DONE is ignored.
    frame(128, 0, 1, 1);
    idle(3);
    chk("done_hold", 32'(wr_done), 1);
    release_buf();

    // Short frame: eop on the 60th beat.
    e0 = err_cnt;
    frame(60, 1, 0, 1);
    chk("short_err_pulse", 32'(frame_err), 1);
    idle(4);
    chk("short_err_cnt", err_cnt - e0, 1);
    chk("short_no_done", 32'(wr_done), 0);
    frame(128, 1, 1, 1);
    idle(3);
    chk("after_short_done", 32'(wr_done), 1);
    release_buf();

    // sop reasserted at beat 40, then 128 more beats.
    e0 = err_cnt;
    frame(40, 1, 0, 0);
    frame(128, 1, 1, 1);
    idle(3);
    chk("resop_err_cnt", err_cnt - e0, 1);
    chk("resop_done", 32'(wr_done), 1);
    release_buf();

    // Reset at beat 70 abandons the frame.
    for (int i = 0; i < 70; i++) beat(i, -2 * i, i == 0, 1'b0, 1'b1, i);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", 32'(wr_en), 0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 0);
    chk("mid_rst_wr_data", 32'(wr_data), 0);
    chk("mid_rst_wr_done", 32'(wr_done), 0);
    chk("mid_rst_frame_err", 32'(frame_err), 0);
    sb.delete();
    @(negedge clk_256k);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) beat(100 + i, 7, 1'b0, i == 5, 1'b0, 0);
    idle(3);
    chk("post_rst_idle", 32'(wr_done), 0);
    frame(128, 1, 0, 1);
    idle(3);
    chk("post_rst_done", 32'(wr_done), 1);

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
